uart_rx: RTL



---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_if.sv | 23 ++
 rtl/sync_2ff.sv | 25 ++
 rtl/uart_rx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and baud-counter sizing.
package uart_pkg;

    localparam int unsigned CNT_W                   = 24;
    localparam int unsigned DEFAULT_CLOCKS_PER_BAUD = 868;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: FIFO write port plus status/interrupt signals.
interface uart_rx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 o_wr;
    logic [DATA_BITS-1:0] o_data;
    logic                 i_fifo_err;
    logic                 i_clr_status;
    logic                 o_frame_err;
    logic                 o_break;
    logic                 o_overrun;
    logic                 o_busy;

    modport master (
        output o_wr, o_data, o_frame_err, o_break, o_overrun, o_busy,
        input  i_fifo_err, i_clr_status
    );

    modport slave (
        input  o_wr, o_data, o_frame_err, o_break, o_overrun, o_busy,
        output i_fifo_err, i_clr_status
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a selectable reset value (idle level of the line).
module sync_2ff #(
    parameter int unsigned     WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: mid-bit sampling, one-cycle FIFO writes,
// framing/break pulses and a sticky overrun flag.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD,
    parameter int unsigned DATA_BITS       = 8
) (
    input  logic      i_clk,
    input  logic      i_reset_n,
    input  logic      i_uart_rx,
    uart_rx_if.master bus
);
    localparam int unsigned        IDX_W    = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(CLOCKS_PER_BAUD - 1);
    localparam logic [CNT_W-1:0]   HALF     = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);

    logic                 rx_sync;
    logic                 rx_s_q;
    state_e               state_q,     state_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] data_q,      data_d;
    logic                 wr_q,        wr_d;
    logic                 frame_err_q, frame_err_d;
    logic                 break_q,     break_d;
    logic                 overrun_q,   overrun_d;
    logic                 busy_q,      busy_d;
    logic                 tick;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .d     (i_uart_rx),
        .q     (rx_sync)
    );

    assign tick = (cnt_q == '0);

    // Next-state, counter, shifter and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = tick ? cnt_q : cnt_q - CNT_W'(1);
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        wr_d        = 1'b0;
        frame_err_d = 1'b0;
        break_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    cnt_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d     = RELOAD;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    cnt_d   = RELOAD;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end
                end
            end
            STOP: begin
                // Counter is left at zero here so the next start edge is caught at once.
                if (tick) begin
                    if (rx_s_q) begin
                        wr_d    = 1'b1;
                        data_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = (shift_q != '0);
                        break_d     = (shift_q == '0);
                        state_d     = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // A new overflow outranks a coincident clear.
        if (bus.i_fifo_err && wr_q) begin
            overrun_d = 1'b1;
        end else if (bus.i_clr_status) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            wr_q        <= 1'b0;
            frame_err_q <= 1'b0;
            break_q     <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_s_q      <= rx_sync;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            wr_q        <= wr_d;
            frame_err_q <= frame_err_d;
            break_q     <= break_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_wr        = wr_q;
    assign bus.o_data      = data_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_break     = break_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_busy      = busy_q;
endmodule
